// File: rtl/sysarr_pkg.sv
// Shared types and default sizing for the systolic-array load sequencer.
package sysarr_pkg;

  localparam int N  = 4;
  localparam int DW = 16;

  typedef enum logic [1:0] {
    WEIGHT  = 2'b00,
    INPUT   = 2'b01,
    PARTIAL = 2'b10,
    RSVD    = 2'b11
  } load_type_t;

  typedef enum logic [1:0] {
    LOAD_W = 2'b00,
    STREAM = 2'b01,
    HOLD   = 2'b10
  } seq_state_t;

  // Issue-queue entry layout at the default array size. The top builds the
  // same layout from its own parameters so it stays correct when resized.
  typedef struct packed {
    logic                  kind;     // 0 = weight row, 1 = input/partial pair
    logic [$clog2(N)-1:0]  row;
    logic [N*DW-1:0]       in_data;
    logic [N*DW-1:0]       ps_data;
  } issue_entry_t;

endpackage

// File: rtl/sysarr_issue_fifo.sv
// Two-entry issue queue; the head is visible combinationally and a push and
// pop in the same cycle both take effect.
module sysarr_issue_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;

  // Next pointer/count/storage from push and pop requests.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  // Queue state registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  assign count = cnt_q;

endmodule

// File: rtl/sysarr_load_sequencer.sv
// Load sequencer: orders weight rows and input/partial-sum row pairs into
// the array control unit through a two-entry issue queue.
//
//   state  | meaning
//   LOAD_W | expecting weight rows in order 0..N-1
//   STREAM | weights loaded; waiting for an input row (or a row-0 reload)
//   HOLD   | input row held; waiting for the partial of the same row
module sysarr_load_sequencer #(
  parameter int N  = sysarr_pkg::N,
  parameter int DW = sysarr_pkg::DW
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_type,
  input  logic [$clog2(N)-1:0] req_row,
  input  logic [N*DW-1:0]      req_data,
  input  logic                 fifo_has_space,
  output logic                 weight_en,
  output logic                 input_en,
  output logic                 partial_en,
  output logic [$clog2(N)-1:0] row_en,
  output logic [N*DW-1:0]      in_data,
  output logic [N*DW-1:0]      ps_data,
  output logic                 weights_loaded,
  output logic                 err
);

  import sysarr_pkg::*;

  localparam int RW = $clog2(N);
  localparam int PW = N * DW;

  typedef struct packed {
    logic          kind;
    logic [RW-1:0] row;
    logic [PW-1:0] in_data;
    logic [PW-1:0] ps_data;
  } entry_t;

  localparam int EW = $bits(entry_t);

  seq_state_t    state_q, state_d;
  logic [RW-1:0] w_cnt_q, w_cnt_d;
  logic [RW-1:0] hold_row_q, hold_row_d;
  logic [PW-1:0] hold_data_q, hold_data_d;
  logic          wl_q, wl_d;
  logic          err_q, err_d;

  load_type_t    req_kind;
  logic          accept;
  logic          push;
  logic          pop;
  entry_t        push_entry;
  entry_t        head;
  logic          fifo_empty;
  logic          fifo_full_unused;
  logic [1:0]    fifo_count;

  assign req_kind  = load_type_t'(req_type);
  // Ready comes from the registered count, so a same-cycle pop cannot raise it.
  assign req_ready = !nRST && (fifo_count < 2'd2);
  assign accept    = req_valid && req_ready;

  sysarr_issue_fifo #(.W(EW)) u_issue_fifo (
    .clk       (clk),
    .rst       (nRST),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full_unused),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // State register and sequencing registers.
  always_ff @(posedge clk or posedge nRST) begin
    if (nRST) begin
      state_q     <= LOAD_W;
      w_cnt_q     <= '0;
      hold_row_q  <= '0;
      hold_data_q <= '0;
      wl_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_cnt_q     <= w_cnt_d;
      hold_row_q  <= hold_row_d;
      hold_data_q <= hold_data_d;
      wl_q        <= wl_d;
      err_q       <= err_d;
    end
  end

  // Next state: classify each accepted request as enqueue, hold, or drop+err.
  always_comb begin
    state_d     = state_q;
    w_cnt_d     = w_cnt_q;
    hold_row_d  = hold_row_q;
    hold_data_d = hold_data_q;
    wl_d        = wl_q;
    err_d       = err_q;
    push        = 1'b0;
    push_entry  = '0;
    if (accept) begin
      if (req_kind == RSVD) begin
        err_d = 1'b1;
      end else begin
        case (state_q)
          LOAD_W: begin
            if (req_kind == WEIGHT && req_row == w_cnt_q) begin
              push               = 1'b1;
              push_entry.row     = req_row;
              push_entry.in_data = req_data;
              if (w_cnt_q == RW'(N - 1)) begin
                w_cnt_d = '0;
                wl_d    = 1'b1;
                state_d = STREAM;
              end else begin
                w_cnt_d = w_cnt_q + RW'(1);
              end
            end else begin
              err_d = 1'b1;
            end
          end
          STREAM: begin
            if (req_kind == INPUT) begin
              hold_row_d  = req_row;
              hold_data_d = req_data;
              state_d     = HOLD;
            end else if (req_kind == WEIGHT && req_row == '0) begin
              // Row-0 weight restarts a full weight reload.
              push               = 1'b1;
              push_entry.row     = req_row;
              push_entry.in_data = req_data;
              wl_d               = 1'b0;
              w_cnt_d            = RW'(1);
              state_d            = LOAD_W;
            end else begin
              err_d = 1'b1;
            end
          end
          HOLD: begin
            if (req_kind == PARTIAL && req_row == hold_row_q) begin
              push               = 1'b1;
              push_entry.kind    = 1'b1;
              push_entry.row     = hold_row_q;
              push_entry.in_data = hold_data_q;
              push_entry.ps_data = req_data;
              state_d            = STREAM;
            end else begin
              err_d = 1'b1;
            end
          end
          default: state_d = LOAD_W;
        endcase
      end
    end
  end

  // Outputs: issue the queue head; pairs wait for room in the control unit.
  always_comb begin
    pop        = !fifo_empty && (!head.kind || fifo_has_space);
    weight_en  = pop && !head.kind;
    input_en   = pop && head.kind;
    partial_en = pop && head.kind;
    row_en     = pop ? head.row     : '0;
    in_data    = pop ? head.in_data : '0;
    ps_data    = pop ? head.ps_data : '0;
  end

  assign weights_loaded = wl_q;
  assign err            = err_q;

endmodule

// File: tb/tb_sysarr_load_sequencer.sv
module tb_sysarr_load_sequencer;

  localparam int N  = 4;
  localparam int DW = 16;

  localparam logic [1:0] T_W = 2'b00;
  localparam logic [1:0] T_I = 2'b01;
  localparam logic [1:0] T_P = 2'b10;
  localparam logic [1:0] T_R = 2'b11;

  logic          clk = 1'b0;
  logic          nRST = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_type = 2'b00;
  logic [1:0]    req_row = 2'b00;
  logic [63:0]   req_data = '0;
  logic          fifo_has_space = 1'b1;
  logic          weight_en, input_en, partial_en;
  logic [1:0]    row_en;
  logic [63:0]   in_data, ps_data;
  logic          weights_loaded, err;

  sysarr_load_sequencer #(.N(N), .DW(DW)) dut (
    .clk            (clk),
    .nRST           (nRST),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_type       (req_type),
    .req_row        (req_row),
    .req_data       (req_data),
    .fifo_has_space (fifo_has_space),
    .weight_en      (weight_en),
    .input_en       (input_en),
    .partial_en     (partial_en),
    .row_en         (row_en),
    .in_data        (in_data),
    .ps_data        (ps_data),
    .weights_loaded (weights_loaded),
    .err            (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        kind;
    logic [1:0]  row;
    logic [63:0] ind;
    logic [63:0] psd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   passed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  function automatic logic [63:0] wrow(input int r);
    return 64'hA0A0_B0B0_C0C0_D000 + 64'(r);
  endfunction

  task automatic push_w(input int r);
    exp_q.push_back('{kind: 1'b0, row: 2'(r), ind: wrow(r), psd: 64'h0});
  endtask

  task automatic push_p(input int r, input logic [63:0] a, input logic [63:0] b);
    exp_q.push_back('{kind: 1'b1, row: 2'(r), ind: a, psd: b});
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [1:0] t, input logic [1:0] row, input logic [63:0] d);
    req_type  = t;
    req_row   = row;
    req_data  = d;
    req_valid = 1'b1;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    if (!req_ready) check("ready_timeout", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_reset(input logic fhs);
    @(posedge clk);
    #1;
    nRST = 1'b1;
    req_valid = 1'b0;
    fifo_has_space = fhs;
    @(negedge clk);
    check("in_rst_ready", req_ready, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    nRST = 1'b0;
    @(negedge clk);
    check("post_rst_ready", req_ready, 1);
    check("post_rst_wl", weights_loaded, 0);
    check("post_rst_err", err, 0);
  endtask

  task automatic load_weights();
    for (int r = 0; r < N; r++) begin
      push_w(r);
      send(T_W, 2'(r), wrow(r));
      check("w_strobe_en", weight_en, 1);
      check("w_strobe_row", row_en, r);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (nRST) begin
      check("rst_strobes", {weight_en, input_en, partial_en}, 0);
      check("rst_ready", req_ready, 0);
    end else if (weight_en || input_en || partial_en) begin
      check("en_exclusive", weight_en & input_en, 0);
      check("pair_paired", input_en, partial_en);
      check("sb_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("sb_kind", input_en, mon_e.kind);
        check("sb_row", row_en, mon_e.row);
        check("sb_in_data", in_data, mon_e.ind);
        if (mon_e.kind) check("sb_ps_data", ps_data, mon_e.psd);
      end
    end else begin
      check("idle_zero", |{row_en, in_data, ps_data}, 0);
    end
  end

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog timeout");
  end

  initial begin
    do_reset(1'b1);

    // Four weight rows back to back.
    load_weights();
    check("wl_after_load", weights_loaded, 1);
    check("err_after_load", err, 0);

    // Row-0 weight while streaming restarts the reload.
    push_w(0);
    send(T_W, 2'd0, wrow(0));
    check("reload_strobe", weight_en, 1);
    check("reload_wl_clear", weights_loaded, 0);
    for (int r = 1; r < N; r++) begin
      push_w(r);
      send(T_W, 2'(r), wrow(r));
    end
    check("reload_wl_set", weights_loaded, 1);

    // Input row 2 then partial row 2.
    send(T_I, 2'd2, 64'h1111_2222_3333_4444);
    check("input_no_strobe", input_en, 0);
    push_p(2, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);
    send(T_P, 2'd2, 64'h5555_6666_7777_8888);
    check("pair_input_en", input_en, 1);
    check("pair_partial_en", partial_en, 1);
    check("pair_row", row_en, 2);
    check("pair_in_data", in_data, 64'h1111_2222_3333_4444);
    check("pair_ps_data", ps_data, 64'h5555_6666_7777_8888);

    // Back-pressure from the control unit.
    @(posedge clk);
    #1 fifo_has_space = 1'b0;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      send(T_I, 2'(p), 64'hC0DE_0000_0000_0000 + 64'(p));
      push_p(p, 64'hC0DE_0000_0000_0000 + 64'(p), 64'hFEED_0000_0000_0000 + 64'(p));
      send(T_P, 2'(p), 64'hFEED_0000_0000_0000 + 64'(p));
      check("bp_no_strobe", input_en, 0);
    end
    check("bp_ready_low", req_ready, 0);
    req_type  = T_I;
    req_row   = 2'd2;
    req_data  = 64'hC0DE_0000_0000_0002;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_held_ready", req_ready, 0);
      check("bp_held_idle", input_en, 0);
    end
    req_valid = 1'b0;
    @(posedge clk);
    #1 fifo_has_space = 1'b1;
    @(negedge clk);
    check("drain0_en", input_en, 1);
    check("drain0_row", row_en, 0);
    @(negedge clk);
    check("drain1_en", input_en, 1);
    check("drain1_row", row_en, 1);
    @(negedge clk);
    check("drain_idle", input_en, 0);
    check("drain_ready", req_ready, 1);
    send(T_I, 2'd2, 64'hC0DE_0000_0000_0002);
    push_p(2, 64'hC0DE_0000_0000_0002, 64'hFEED_0000_0000_0002);
    send(T_P, 2'd2, 64'hFEED_0000_0000_0002);
    check("third_pair_en", input_en, 1);
    check("stream_err_clear", err, 0);

    // Input before weights loaded.
    do_reset(1'b1);
    send(T_I, 2'd0, 64'h1);
    check("e_input_early_err", err, 1);
    check("e_input_early_idle", input_en | weight_en, 0);

    // Weight row out of order.
    do_reset(1'b1);
    send(T_W, 2'd1, wrow(1));
    check("e_wrow_err", err, 1);
    check("e_wrow_idle", weight_en, 0);
    check("e_wrow_wl", weights_loaded, 0);

    // Mismatched partial row keeps the held input.
    do_reset(1'b1);
    load_weights();
    send(T_I, 2'd1, 64'hAAAA_0000_0000_0001);
    check("e_hold_err_before", err, 0);
    send(T_P, 2'd3, 64'hBBBB_0000_0000_0003);
    check("e_prow_err", err, 1);
    check("e_prow_idle", input_en, 0);
    push_p(1, 64'hAAAA_0000_0000_0001, 64'hBBBB_0000_0000_0001);
    send(T_P, 2'd1, 64'hBBBB_0000_0000_0001);
    check("e_prow_kept_en", input_en, 1);
    check("e_prow_kept_data", in_data, 64'hAAAA_0000_0000_0001);
    check("e_err_sticky", err, 1);

    // Reserved type leaves the weight counter alone.
    do_reset(1'b1);
    send(T_R, 2'd0, 64'h2);
    check("e_rsvd_err", err, 1);
    check("e_rsvd_idle", weight_en | input_en, 0);
    push_w(0);
    send(T_W, 2'd0, wrow(0));
    check("e_rsvd_w0_en", weight_en, 1);

    // Reset with one pair queued and an input held.
    do_reset(1'b1);
    load_weights();
    @(posedge clk);
    #1 fifo_has_space = 1'b0;
    @(negedge clk);
    send(T_I, 2'd0, 64'h0123);
    send(T_P, 2'd0, 64'h4567);
    send(T_I, 2'd1, 64'h89AB);
    check("mid_queued_idle", input_en, 0);
    check("mid_ready", req_ready, 1);
    exp_q.delete();
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_post_idle", input_en | weight_en, 0);
    end
    send(T_I, 2'd0, 64'h1);
    check("mid_load_w_err", err, 1);

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sysarr_load_sequencer.md
SYSARR_LOAD_SEQUENCER -- requirements
Module: sysarr_load_sequencer

Interface
REQ-001 SHALL have parameters: N, default 4, array rows/cols; DW, default 16, element width in bits.
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
- clk  in  1  rising-edge clock
- nRST  in  1  reset, active-high despite the name
- req_valid  in  1  load request valid
- req_ready  out  1  sequencer can accept a request
- req_type  in  2  00 weight, 01 input, 10 partial, 11 reserved
- req_row  in  $clog2(N)  target row
- req_data  in  N*DW  row payload
- fifo_has_space  in  1  control unit can take an input/partial pair
- weight_en  out  1  one-cycle weight-row strobe to control unit
- input_en  out  1  one-cycle input strobe, always paired with partial_en
- partial_en  out  1  one-cycle partial strobe, always paired with input_en
- row_en  out  $clog2(N)  row of current strobe
- in_data  out  N*DW  weight row or input row
- ps_data  out  N*DW  partial-sum row, valid with partial_en
- weights_loaded  out  1  all N weight rows issued
- err  out  1  sticky protocol-error flag

Function
REQ-003 SHALL accept a request on a clock edge where req_valid && req_ready.
REQ-004 req_ready SHALL be 1 iff the issue queue holds fewer than 2 entries; a pop in the same cycle SHALL NOT raise it.
REQ-005 FSM states: LOAD_W (reset state), STREAM, HOLD.
REQ-006 LOAD_W: weight with req_row == w_cnt SHALL enqueue and increment w_cnt; when w_cnt reaches N, weights_loaded SHALL set, w_cnt wraps to 0, next state is STREAM.
REQ-007 LOAD_W: any input/partial, or a weight with req_row != w_cnt, SHALL be dropped and set err.
REQ-008 STREAM: input SHALL be captured into the hold register with its row, next state HOLD; nothing is enqueued.
REQ-009 STREAM: weight with row 0 SHALL clear weights_loaded, enqueue, set w_cnt=1, next state LOAD_W; weight with row != 0 and partial SHALL be dropped with err.
REQ-010 HOLD: partial with req_row equal to the held row SHALL enqueue a pair entry {row, held input, partial}, next state STREAM.
REQ-011 HOLD: partial with a mismatched row, a second input, or any weight SHALL be dropped with err; the held input is kept.
REQ-012 Reserved type 11 SHALL be dropped with err in every state.
REQ-013 Accepted-but-dropped requests SHALL still complete the handshake, with no change to queue or counters.
REQ-014 Issue queue: 2-entry FIFO of {kind, row, in_data, ps_data}.
- The head SHALL issue combinationally and pop in the same cycle.
- Weight kind: issues unconditionally.
- Pair kind: issues only when fifo_has_space = 1.
REQ-015 Latency: a weight accepted at edge k into an empty queue SHALL strobe weight_en in the cycle after edge k; a pair SHALL strobe in the cycle after the partial is accepted, if fifo_has_space = 1.
REQ-016 Strobes SHALL be exactly one cycle per entry; weight_en and input_en SHALL never both be high.
REQ-017 A push and a pop in the same cycle SHALL both occur; count is unchanged.
REQ-018 When no strobe is active, in_data, ps_data and row_en SHALL be 0.
REQ-019 err SHALL remain set until reset.

Reset
REQ-020 When nRST = 1, the block SHALL asynchronously go to LOAD_W and clear w_cnt, the hold register, the queue, weights_loaded and err.
REQ-021 During reset, all strobes SHALL be 0 and req_ready SHALL be 0.
REQ-022 After reset, req_ready SHALL be 1 in the first cycle.
REQ-023 Reset mid-operation SHALL discard queued and held data without emitting any strobe.

Structure
REQ-024 Package sysarr_pkg SHALL hold N, DW, load_type_t (WEIGHT, INPUT, PARTIAL, RSVD), seq_state_t and the queue-entry struct.
REQ-025 The 2-entry queue SHALL be a sub-module named sysarr_issue_fifo (push, pop, full, empty, count).

Verification
REQ-026 Weights rows 0..3 back-to-back, fifo_has_space = 1 -> weight_en strobes with row_en 0,1,2,3 on consecutive cycles; weights_loaded = 1 after the 4th strobe; err = 0.
REQ-027 Input row 2 (data A), then partial row 2 (data B), fifo_has_space = 1 -> one cycle with input_en = partial_en = 1, row_en = 2, in_data = A, ps_data = B.
REQ-028 Hold fifo_has_space = 0 and send 3 pairs -> req_ready drops after the 2nd pair enters the queue; no strobes; raise fifo_has_space -> 2 pair strobes on consecutive cycles, then req_ready = 1.
REQ-029 Error cases -> err = 1 and no strobe for each:
- input before weights are loaded
- weight row 1 when row 0 is expected
- partial row 3 while row 1 is held
- type 11
REQ-030 Assert nRST while one entry is queued and an input is held; release -> no strobe, weights_loaded = 0, LOAD_W, req_ready = 1 on the next cycle.
